// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC sequencer. Holds the X/Y/Z working registers,
// feeds one micro-rotation per ISSUE/WAIT pair to external registered adders.
module cordic_iter_ctrl #(
    parameter int WIDTH      = 16,
    parameter int ITERATIONS = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] X_in,
    input  logic [WIDTH-1:0] Y_in,
    input  logic [WIDTH-1:0] Z_in,
    input  logic [WIDTH-1:0] Cordic_x,
    input  logic [WIDTH-1:0] Cordic_y,
    output logic [WIDTH-1:0] X_i,
    output logic [WIDTH-1:0] Y_i,
    output logic [WIDTH-1:0] Shifted_y,
    output logic [WIDTH-1:0] Shifted_x,
    output logic             Enable,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] X_out,
    output logic [WIDTH-1:0] Y_out,
    output logic [WIDTH-1:0] Z_out,
    output logic [1:0]       dbg_state
);

    // Handshake: Start is taken only in IDLE (never queued); Busy covers the
    // ISSUE/WAIT cycles; Done is a one-cycle pulse with X_out/Y_out/Z_out valid
    // and held until the next Done. Enable is a one-cycle strobe to the adders,
    // whose registered results on Cordic_x/Cordic_y are captured the next cycle.

    localparam int               IW        = $clog2(WIDTH + 1);
    localparam logic [IW-1:0]    LAST_ITER = IW'(ITERATIONS - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS  = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] x_out_q, x_out_d;
    logic [WIDTH-1:0] y_out_q, y_out_d;
    logic [WIDTH-1:0] z_out_q, z_out_d;

    logic             dir_neg;
    logic [WIDTH-1:0] x_shr;
    logic [WIDTH-1:0] y_shr;
    logic [WIDTH-1:0] atan_val;
    logic [WIDTH-1:0] z_step;

    // arctan(2^-i) in Q3.13; terms beyond i=15 round to zero.
    function automatic logic [WIDTH-1:0] atan_lut(input logic [IW-1:0] idx);
        logic [WIDTH-1:0] v;
        case (idx)
            IW'(0):  v = WIDTH'(6434);
            IW'(1):  v = WIDTH'(3798);
            IW'(2):  v = WIDTH'(2007);
            IW'(3):  v = WIDTH'(1019);
            IW'(4):  v = WIDTH'(511);
            IW'(5):  v = WIDTH'(256);
            IW'(6):  v = WIDTH'(128);
            IW'(7):  v = WIDTH'(64);
            IW'(8):  v = WIDTH'(32);
            IW'(9):  v = WIDTH'(16);
            IW'(10): v = WIDTH'(8);
            IW'(11): v = WIDTH'(4);
            IW'(12): v = WIDTH'(2);
            IW'(13): v = WIDTH'(1);
            IW'(14): v = WIDTH'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Two's-complement negate that clamps the most negative value.
    function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v == MOST_NEG) begin
            r = MOST_POS;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = (i_q == LAST_ITER) ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Enable    = (state_q == S_ISSUE);
        Busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
        Done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // Direction comes from the Z register, which only changes at the end of
    // WAIT, so it is stable across the whole ISSUE/WAIT pair.
    always_comb begin
        dir_neg   = z_q[WIDTH-1];
        x_shr     = $signed(x_q) >>> i_q;
        y_shr     = $signed(y_q) >>> i_q;
        atan_val  = atan_lut(i_q);
        z_step    = dir_neg ? (z_q + atan_val) : (z_q - atan_val);
        X_i       = x_q;
        Y_i       = y_q;
        Shifted_x = dir_neg ? sat_neg(x_shr) : x_shr;
        Shifted_y = dir_neg ? y_shr : sat_neg(y_shr);
    end

    // Working-register and result next values
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    x_d = X_in;
                    y_d = Y_in;
                    z_d = Z_in;
                    i_d = '0;
                end
            end
            S_WAIT: begin
                x_d = Cordic_x;
                y_d = Cordic_y;
                z_d = z_step;
                i_d = i_q + IW'(1);
                if (i_q == LAST_ITER) begin
                    x_out_d = Cordic_x;
                    y_out_d = Cordic_y;
                    z_out_d = z_step;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
        end
    end

    assign X_out = x_out_q;
    assign Y_out = y_out_q;
    assign Z_out = z_out_q;

endmodule
